// File: rtl/mem_interface.sv
// mem_interface: memory access stage between the microprogrammed control
// unit and a word-wide, waitrequest-style bus. Turns level-held mem_read /
// mem_write requests into single bus transactions, steers store bytes onto
// the proper lanes and extracts/extends load data.
//
// Optional build macro: MEM_IF_MISALIGN_TRAP_EN
//   defined   - misaligned accesses bypass the bus and complete with a
//               misaligned pulse
//   undefined - misaligned is tied 0 and offending low address bits are
//               ignored for lane selection
module mem_interface #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [2:0]        funct3,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_complete_read,
   output logic              mem_complete_write,
   output logic              busy,
   output logic              misaligned,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              bus_read,
   output logic              bus_write,
   output logic [3:0]        bus_byteenable,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_waitrequest,
   input  logic              bus_readdatavalid
);

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WR_REQ,
      DONE
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   state_t            state;
   state_t            state_next;
   logic              capture;
   logic              trap_req;
   logic [ADDR_W-1:0] req_addr;
   logic [2:0]        req_funct3;
   logic [DATA_W-1:0] req_wdata;
   logic              req_write;

   // Access size: stores only know SB/SH/SW (everything else is a word),
   // loads treat the unsigned encodings like their signed counterparts.
   function automatic logic [1:0] access_size(input logic is_write, input logic [2:0] f3);
      logic [1:0] sz;
      sz = SZ_WORD;
      if (is_write) begin
         case (f3)
            3'b000:  sz = SZ_BYTE;
            3'b001:  sz = SZ_HALF;
            default: sz = SZ_WORD;
         endcase
      end else begin
         case (f3)
            3'b000, 3'b100: sz = SZ_BYTE;
            3'b001, 3'b101: sz = SZ_HALF;
            default:        sz = SZ_WORD;
         endcase
      end
      return sz;
   endfunction

   // Lane enables: bytes pick one lane, halves pick by addr[1], words use all.
   function automatic logic [3:0] lane_enable(input logic [1:0] sz, input logic [1:0] off);
      logic [3:0] be;
      case (sz)
         SZ_BYTE: be = 4'b0001 << off;
         SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Store data is replicated across lanes so the byteenable alone selects it.
   function automatic logic [31:0] steer_store(input logic [1:0] sz, input logic [31:0] d);
      logic [31:0] s;
      case (sz)
         SZ_BYTE: s = {4{d[7:0]}};
         SZ_HALF: s = {2{d[15:0]}};
         default: s = d;
      endcase
      return s;
   endfunction

   // Load data is pulled out of its lane and sign- or zero-extended.
   function automatic logic [31:0] extract_load(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'd0:    b = d[7:0];
         2'd1:    b = d[15:8];
         2'd2:    b = d[23:16];
         default: b = d[31:24];
      endcase
      h = off[1] ? d[31:16] : d[15:0];
      case (f3)
         3'b000:  r = {{24{b[7]}}, b};
         3'b100:  r = {24'd0, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b101:  r = {16'd0, h};
         default: r = d;
      endcase
      return r;
   endfunction

`ifdef MEM_IF_MISALIGN_TRAP_EN
   logic req_mis;
   logic half_op;

   // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
   always_comb begin
      half_op  = (funct3 == 3'b001) || (!mem_write && funct3 == 3'b101);
      trap_req = (half_op && addr[0]) || (funct3 == 3'b010 && addr[1:0] != 2'b00);
   end

   // Remember whether the accepted request trapped, for the DONE pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         req_mis <= 1'b0;
      else if (state == IDLE && (mem_read || mem_write))
         req_mis <= trap_req;
   end

   assign misaligned = (state == DONE) && req_mis;
`else
   assign trap_req   = 1'b0;
   assign misaligned = 1'b0;
`endif

   // State register, request capture and load-data capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         req_addr   <= '0;
         req_funct3 <= 3'b000;
         req_wdata  <= '0;
         req_write  <= 1'b0;
         rdata      <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && (mem_read || mem_write)) begin
            req_addr   <= addr;
            req_funct3 <= funct3;
            req_write  <= mem_write;
            if (mem_write)
               req_wdata <= wdata;
         end
         if (capture)
            rdata <= extract_load(req_funct3, req_addr[1:0], bus_rdata);
      end
   end

   // Next-state logic; requests are only looked at in IDLE, write wins.
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (mem_write || mem_read) begin
               if (trap_req)
                  state_next = DONE;
               else if (mem_write)
                  state_next = WR_REQ;
               else
                  state_next = RD_REQ;
            end
         end
         RD_REQ: begin
            if (!bus_waitrequest) begin
               if (bus_readdatavalid) begin
                  capture    = 1'b1;
                  state_next = DONE;
               end else begin
                  state_next = RD_WAIT;
               end
            end
         end
         RD_WAIT: begin
            if (bus_readdatavalid) begin
               capture    = 1'b1;
               state_next = DONE;
            end
         end
         WR_REQ: begin
            if (!bus_waitrequest)
               state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy               = (state != IDLE);
   assign bus_read           = (state == RD_REQ);
   assign bus_write          = (state == WR_REQ);
   assign bus_addr           = {req_addr[ADDR_W-1:2], 2'b00};
   assign bus_byteenable     = (bus_read || bus_write)
                               ? lane_enable(access_size(req_write, req_funct3), req_addr[1:0])
                               : 4'b0000;
   assign bus_wdata          = steer_store(access_size(req_write, req_funct3), req_wdata);
   assign mem_complete_read  = (state == DONE) && !req_write;
   assign mem_complete_write = (state == DONE) && req_write;

   // The control unit must never raise both requests at once.
   assert property (@(posedge clk) disable iff (rst)
                    !(state == IDLE && mem_read && mem_write));

endmodule

// File: tb/tb_mem_interface.sv
// tb_mem_interface: self-checking bench for mem_interface (default build,
// MEM_IF_MISALIGN_TRAP_EN undefined). Directed vector table, reset corner
// case and randomized transactions against a behavioural model.
module tb_mem_interface;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] addr;
   logic [2:0]  funct3;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        mem_complete_read;
   logic        mem_complete_write;
   logic        busy;
   logic        misaligned;
   logic [31:0] bus_addr;
   logic        bus_read;
   logic        bus_write;
   logic [3:0]  bus_byteenable;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_waitrequest;
   logic        bus_readdatavalid;

   int          total = 0;
   int          bad = 0;
   logic [31:0] model_rdata = 32'd0;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [2:0]  f3;
      logic [31:0] wdata;
      logic [31:0] brdata;
      int          ws;
      int          vd;
      logic [3:0]  exp_be;
      logic [31:0] exp_bwdata;
      logic [31:0] exp_rdata;
      int          exp_lat;
   } vec_t;

   mem_interface #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk                (clk),
      .rst                (rst),
      .mem_read           (mem_read),
      .mem_write          (mem_write),
      .addr               (addr),
      .funct3             (funct3),
      .wdata              (wdata),
      .rdata              (rdata),
      .mem_complete_read  (mem_complete_read),
      .mem_complete_write (mem_complete_write),
      .busy               (busy),
      .misaligned         (misaligned),
      .bus_addr           (bus_addr),
      .bus_read           (bus_read),
      .bus_write          (bus_write),
      .bus_byteenable     (bus_byteenable),
      .bus_wdata          (bus_wdata),
      .bus_rdata          (bus_rdata),
      .bus_waitrequest    (bus_waitrequest),
      .bus_readdatavalid  (bus_readdatavalid)
   );

   // Free-running core clock.
   always #5 clk = ~clk;

   // Access size in bytes, straight from the RISC-V encodings.
   function automatic int modelBytes(input logic wr, input logic [2:0] f3);
      if (wr) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
      if (f3 == 3'd0 || f3 == 3'd4) return 1;
      if (f3 == 3'd1 || f3 == 3'd5) return 2;
      return 4;
   endfunction

   function automatic logic [3:0] modelBe(input logic wr, input logic [2:0] f3, input logic [31:0] a);
      int n;
      n = modelBytes(wr, f3);
      if (n == 1) return 4'(1 << (a % 4));
      if (n == 2) return 4'(3 << (2 * ((a / 2) % 2)));
      return 4'hF;
   endfunction

   function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] d);
      int n;
      n = modelBytes(1'b1, f3);
      if (n == 1) return (d % 256) * 32'h0101_0101;
      if (n == 2) return (d % 65536) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      longint v;
      int n;
      n = modelBytes(1'b0, f3);
      if (n == 1) begin
         v = (d >> (8 * (a % 4))) % 256;
         if (f3 == 3'd0 && v >= 128) v = v - 256;
      end else if (n == 2) begin
         v = (d >> (16 * ((a / 2) % 2))) % 65536;
         if (f3 == 3'd1 && v >= 32768) v = v - 65536;
      end else begin
         v = d;
      end
      return 32'(v);
   endfunction

   function automatic vec_t mk(input logic wr, input logic [31:0] a, input logic [2:0] f3,
                               input logic [31:0] wd, input logic [31:0] rd, input int ws, input int vd,
                               input logic [3:0] be, input logic [31:0] bwd, input logic [31:0] rdv);
      vec_t v;
      v.wr = wr; v.addr = a; v.f3 = f3; v.wdata = wd; v.brdata = rd;
      v.ws = ws; v.vd = vd; v.exp_be = be; v.exp_bwdata = bwd; v.exp_rdata = rdv;
      v.exp_lat = wr ? (2 + ws) : (2 + ws + vd);
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   // Runs one transaction, acting as the bus slave and checking each cycle.
   task automatic applyStimulus(input vec_t v);
      int   stall;
      int   acc_cyc;
      int   done_cyc;
      int   strobes;
      logic accepted;
      logic [31:0] exp_baddr;
      exp_baddr = v.addr & 32'hFFFF_FFFC;
      stall     = v.ws;
      acc_cyc   = 0;
      done_cyc  = -1;
      strobes   = 0;
      accepted  = 1'b0;
      checkOutput("busy_before", busy, 0);
      mem_write = v.wr;
      mem_read  = !v.wr;
      addr      = v.addr;
      funct3    = v.f3;
      wdata     = v.wdata;
      for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
         @(posedge clk); #1;
         bus_waitrequest   = 1'b0;
         bus_readdatavalid = 1'b0;
         bus_rdata         = $urandom;
         if (mem_complete_read || mem_complete_write) begin
            done_cyc  = c;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            checkOutput("cpl_read", mem_complete_read, !v.wr);
            checkOutput("cpl_write", mem_complete_write, v.wr);
            checkOutput("latency", c, v.exp_lat);
            checkOutput("strobe_cycles", strobes, v.ws + 1);
            checkOutput("misaligned", misaligned, 0);
            checkOutput("busy_done", busy, 1);
            if (!v.wr) model_rdata = v.exp_rdata;
            checkOutput("rdata", rdata, model_rdata);
         end else begin
            checkOutput("busy_mid", busy, 1);
            if (bus_read || bus_write) begin
               strobes++;
               checkOutput("bus_write", bus_write, v.wr);
               checkOutput("bus_read", bus_read, !v.wr);
               checkOutput("bus_addr", bus_addr, exp_baddr);
               checkOutput("byteenable", bus_byteenable, v.exp_be);
               if (v.wr) checkOutput("bus_wdata", bus_wdata, v.exp_bwdata);
               if (stall > 0) begin
                  bus_waitrequest = 1'b1;
                  stall--;
               end else begin
                  accepted = 1'b1;
                  acc_cyc  = c;
               end
            end
            if (!v.wr && accepted && (c - acc_cyc) == v.vd) begin
               bus_readdatavalid = 1'b1;
               bus_rdata         = v.brdata;
            end
         end
      end
      if (done_cyc < 0) begin
         total++;
         bad++;
         $display("[TB] FAIL timeout: no completion, expected one within %0d cycles", v.exp_lat);
         mem_read  = 1'b0;
         mem_write = 1'b0;
      end
      @(posedge clk); #1;
      checkOutput("single_pulse", {mem_complete_read, mem_complete_write}, 0);
      checkOutput("busy_after", busy, 0);
   endtask

   vec_t vecs[12];
   vec_t rv;

   initial begin
      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; funct3 = '0; wdata = '0;
      bus_rdata = '0; bus_waitrequest = 1'b0; bus_readdatavalid = 1'b0;

      vecs[0]  = mk(0, 32'h100, 3'b010, 0, 32'h0050_0093, 0, 1, 4'b1111, 0, 32'h0050_0093);
      vecs[1]  = mk(0, 32'h203, 3'b000, 0, 32'h80FF_0000, 0, 1, 4'b1000, 0, 32'hFFFF_FF80);
      vecs[2]  = mk(0, 32'h203, 3'b100, 0, 32'h80FF_0000, 0, 1, 4'b1000, 0, 32'h0000_0080);
      vecs[3]  = mk(1, 32'h302, 3'b001, 32'h1234_ABCD, 0, 3, 0, 4'b1100, 32'hABCD_ABCD, 0);
      vecs[4]  = mk(0, 32'h010, 3'b010, 0, 32'hDEAD_BEEF, 2, 4, 4'b1111, 0, 32'hDEAD_BEEF);
      vecs[5]  = mk(0, 32'h002, 3'b001, 0, 32'h8001_1234, 0, 1, 4'b1100, 0, 32'hFFFF_8001);
      vecs[6]  = mk(0, 32'h000, 3'b101, 0, 32'h8001_F234, 1, 2, 4'b0011, 0, 32'h0000_F234);
      vecs[7]  = mk(1, 32'h501, 3'b000, 32'h1234_56A5, 0, 0, 0, 4'b0010, 32'hA5A5_A5A5, 0);
      vecs[8]  = mk(1, 32'h600, 3'b010, 32'h1122_3344, 0, 1, 0, 4'b1111, 32'h1122_3344, 0);
      vecs[9]  = mk(0, 32'h001, 3'b000, 0, 32'h0000_7F00, 0, 0, 4'b0010, 0, 32'h0000_007F);
      vecs[10] = mk(0, 32'h401, 3'b010, 0, 32'hCAFE_F00D, 0, 1, 4'b1111, 0, 32'hCAFE_F00D);
      vecs[11] = mk(0, 32'h003, 3'b101, 0, 32'h7FFF_0001, 0, 1, 4'b1100, 0, 32'h0000_7FFF);

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_rdata", rdata, 0);
      checkOutput("rst_strobes", {bus_read, bus_write}, 0);
      checkOutput("rst_be", bus_byteenable, 0);
      checkOutput("rst_bus_addr", bus_addr, 0);
      checkOutput("rst_bus_wdata", bus_wdata, 0);
      checkOutput("rst_flags", {busy, mem_complete_read, mem_complete_write, misaligned}, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

      // Reset while the read sits in RD_WAIT, then a stale data response.
      mem_read = 1'b1; addr = 32'h700; funct3 = 3'b010;
      @(posedge clk); #1;
      checkOutput("rst_seq_rd_req", bus_read, 1);
      @(posedge clk); #1;
      checkOutput("rst_seq_rd_wait", {bus_read, busy}, 2'b01);
      rst = 1'b1;
      #1;
      checkOutput("rst_async_strobe", {bus_read, bus_write, busy}, 0);
      checkOutput("rst_async_be", bus_byteenable, 0);
      checkOutput("rst_async_rdata", rdata, 0);
      mem_read = 1'b0;
      model_rdata = 32'd0;
      @(posedge clk); #1;
      rst = 1'b0;
      bus_readdatavalid = 1'b1;
      bus_rdata = 32'hBAD0_BAD0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checkOutput("stale_cpl", {mem_complete_read, mem_complete_write}, 0);
         checkOutput("stale_rdata", rdata, 0);
         checkOutput("stale_busy", busy, 0);
      end
      bus_readdatavalid = 1'b0;
      applyStimulus(vecs[0]);

      // Randomized transactions against the behavioural model.
      for (int i = 0; i < 40; i++) begin
         rv.wr     = 1'($urandom_range(0, 1));
         rv.addr   = $urandom & 32'h0000_FFFF;
         rv.f3     = 3'($urandom_range(0, 7));
         rv.wdata  = $urandom;
         rv.brdata = $urandom;
         rv.ws     = $urandom_range(0, 3);
         rv.vd     = $urandom_range(0, 3);
         rv.exp_be = modelBe(rv.wr, rv.f3, rv.addr);
         rv.exp_bwdata = modelWdata(rv.f3, rv.wdata);
         rv.exp_rdata  = modelLoad(rv.f3, rv.addr, rv.brdata);
         rv.exp_lat    = rv.wr ? (2 + rv.ws) : (2 + rv.ws + rv.vd);
         applyStimulus(rv);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
